uart_tx: RTL and testbench

//  Serialises parallel words onto an asynchronous UART line: 1 start bit, WORD_LENGTH data bits LSB-first,

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver:
//   - uart_state_e  : frame FSM state encoding
//   - PARITY_*      : parity mode constants for the PARITY parameter
//   - clks_per_bit  : baud divider derivation (integer divide)
//   - calc_parity   : parity bit from the XOR-reduction of a data word
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  // data_xor is ^data; even parity transmits it as-is, odd parity inverts it.
  function automatic logic calc_parity(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Small synchronous first-word-fall-through FIFO feeding the transmitter.
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//     push, din      : write din when push && !full
//     pop            : drop the head word when pop && !empty
//     dout           : current head word (valid whenever !empty)
//     full, empty    : occupancy flags
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter: 1 start bit, WORD_LENGTH data bits LSB first, optional
//   parity bit, STOP_BITS stop bits. Words queue in a small FIFO and queued
//   words go out back-to-back with no idle gap.
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset
//     i_tx_valid     : producer offers i_tx_byte
//     o_tx_ready     : FIFO not full (and not in reset); accept on valid&&ready
//     i_tx_byte      : word to send
//     o_tx_serial    : registered UART line, idle high
//     o_tx_busy      : registered, high while a frame is in flight or queued
//     o_tx_done      : one-cycle pulse after the last stop bit of each frame
// ----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int WORD_LENGTH = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  input  logic [WORD_LENGTH-1:0] i_tx_byte,
  output logic                   o_tx_serial,
  output logic                   o_tx_busy,
  output logic                   o_tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
  // One extra bit so the counter can span a double stop bit.
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(WORD_LENGTH) + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(WORD_LENGTH - 1);

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          idx_q, idx_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   serial_q, serial_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic                   push_fire;
  logic                   fifo_pop;
  logic                   load_word;
  logic                   fifo_full, fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_dout;

  // Ready is forced low while reset is held; the FIFO itself only clears
  // at the reset edge.
  assign o_tx_ready = i_rst_n && !fifo_full;
  assign push_fire  = i_tx_valid && o_tx_ready;

  uart_tx_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_fire),
    .pop     (fifo_pop),
    .din     (i_tx_byte),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    load_word = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        load_word = !fifo_empty;
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = ST_DATA;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (PARITY != PARITY_NONE) begin
              state_d  = ST_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            // Next bit is shift_q[1] now; after the shift it sits at [0].
            idx_d    = idx_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = ST_STOP;
          cnt_d    = '0;
          serial_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (!fifo_empty) begin
            load_word = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Pop the head word and start its frame; parity is frozen here.
    if (load_word) begin
      state_d  = ST_START;
      cnt_d    = '0;
      idx_d    = '0;
      shift_d  = fifo_dout;
      par_d    = calc_parity(^fifo_dout, PARITY);
      serial_d = 1'b0;
    end
    fifo_pop = load_word;

    // Any pop coincides with a move to START, so "push or non-empty"
    // covers the FIFO's post-edge occupancy exactly.
    busy_d = (state_d != ST_IDLE) || push_fire || !fifo_empty;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_busy   = busy_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//   Three transmitters share one stimulus stream:
//     u0: no parity, 1 stop bit   u1: even parity, 2 stop bits
//     u2: odd parity, 1 stop bit
//   Each has a reference model that expands every accepted word into the
//   expected per-cycle line waveform (start, data LSB first, parity, stops)
//   and derives busy, done and ready from it.
// ----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int NI    = 3;
  localparam int DEPTH = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_byte  = 8'h00;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] tx_serial;
  logic [NI-1:0] tx_busy;
  logic [NI-1:0] tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int PAR  = (gi == 1) ? 2 : (gi == 2) ? 1 : 0;
    localparam int STOP = (gi == 1) ? 2 : 1;

    uart_tx #(
      .CLK_RATE    (16),
      .BAUD_RATE   (1),
      .WORD_LENGTH (8),
      .PARITY      (PAR),
      .STOP_BITS   (STOP),
      .FIFO_DEPTH  (DEPTH)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_tx_valid  (tx_valid),
      .o_tx_ready  (tx_ready[gi]),
      .i_tx_byte   (tx_byte),
      .o_tx_serial (tx_serial[gi]),
      .o_tx_busy   (tx_busy[gi]),
      .o_tx_done   (tx_done[gi])
    );

    // Per-cycle expected line: 0/1 plain level, 2 = last stop cycle (high),
    // 3 = first start cycle (low, marks the FIFO pop).
    int q[$];
    int occ       = 0;
    int acc_cnt   = 0;
    bit fire_prev = 1'b0;
    bit done_next = 1'b0;
    bit rst_prev  = 1'b0;

    function automatic void add_frame(input logic [7:0] w);
      int ones;
      bit p;
      ones = 0;
      q.push_back(3);
      for (int c = 1; c < CPB; c++) q.push_back(0);
      for (int b = 0; b < 8; b++) begin
        ones += int'(w[b]);
        for (int c = 0; c < CPB; c++) q.push_back(int'(w[b]));
      end
      if (PAR != 0) begin
        // Even: p makes the total count of ones even only with p = ones%2.
        p = (PAR == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
        for (int c = 0; c < CPB; c++) q.push_back(int'(p));
      end
      for (int c = 1; c < STOP * CPB; c++) q.push_back(1);
      q.push_back(2);
    endfunction

    always @(negedge clk) begin : mon
      int e;
      bit from_q;
      bit exp_done;
      bit exp_ready;
      if (!rst_prev) begin
        q.delete();
        occ       = 0;
        fire_prev = 1'b0;
        done_next = 1'b0;
        chk($sformatf("u%0d_rst_line", gi), 32'(tx_serial[gi]), 32'd1);
        chk($sformatf("u%0d_rst_busy", gi), 32'(tx_busy[gi]), 32'd0);
        chk($sformatf("u%0d_rst_done", gi), 32'(tx_done[gi]), 32'd0);
      end else begin
        exp_done  = done_next;
        done_next = 1'b0;
        if (fire_prev) occ++;
        from_q = (q.size() > 0);
        e = from_q ? q.pop_front() : 1;
        if (e == 3) occ--;
        if (e == 2) done_next = 1'b1;
        chk($sformatf("u%0d_line", gi), 32'(tx_serial[gi]), (e == 1 || e == 2) ? 32'd1 : 32'd0);
        chk($sformatf("u%0d_busy", gi), 32'(tx_busy[gi]), 32'(from_q));
        chk($sformatf("u%0d_done", gi), 32'(tx_done[gi]), 32'(exp_done));
      end
      exp_ready = rst_n && (occ < DEPTH);
      chk($sformatf("u%0d_ready", gi), 32'(tx_ready[gi]), 32'(exp_ready));
      if (tx_valid && tx_ready[gi]) acc_cnt++;
      fire_prev = tx_valid && exp_ready;
      if (fire_prev) begin
        $display("u%0d accept %02h t=%0t", gi, tx_byte, $time);
        // An idle FIFO spends one cycle before the start bit appears.
        if (q.size() == 0) q.push_back(1);
        add_frame(tx_byte);
      end
      rst_prev = rst_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_byte  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (tx_busy == '0) break;
      tick();
    end
    chk("wait_idle", 32'(tx_busy), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int snap;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    send(8'hA5);
    wait_idle(1000);
    send(8'h07);
    wait_idle(1000);
    send(8'hFF);
    wait_idle(1000);

    // Back-to-back pair
    tx_valid = 1'b1;
    tx_byte  = 8'h55;
    tick();
    tx_byte  = 8'hAA;
    tick();
    tx_valid = 1'b0;
    wait_idle(1000);

    // Hold valid for 10 cycles: one word popped plus a full FIFO
    snap = g_dut[0].acc_cnt;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx_byte = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("hold10_accepts", 32'(g_dut[0].acc_cnt - snap), 32'd5);
    wait_idle(3000);

    // Reset during data bit 3 with two words queued
    tx_valid = 1'b1;
    tx_byte  = 8'h3C;
    tick();
    tx_byte  = 8'hC3;
    tick();
    tx_byte  = 8'h81;
    tick();
    tx_valid = 1'b0;
    repeat (64) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (400) tick();
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      tx_valid = ($urandom_range(0, 99) < 3);
      tx_byte  = 8'($urandom);
      rst_n    = ($urandom_range(0, 1499) != 0);
      tick();
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    wait_idle(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
